// File: rtl/cv32e40x_fencei_flush_unit.sv
// System-side responder for the core's fence.i handshake: drains the data write
// path, optionally invalidates the instruction cache, then pulses ack for one cycle.
module cv32e40x_fencei_flush_unit #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter bit          ICACHE_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fencei_flush_req_i,
  output logic             fencei_flush_ack_o,
  input  logic             dbuf_empty_i,
  output logic             dbuf_drain_o,
  output logic             icache_inv_req_o,
  input  logic             icache_inv_gnt_i,
  input  logic             icache_inv_done_i,
  output logic             flush_busy_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             drain_timeout_o
);

  localparam int unsigned DCNT_W = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam bit                TIMEOUT_EN = (DRAIN_TIMEOUT != 0);
  localparam logic [DCNT_W-1:0] TIMEOUT_V  = DCNT_W'(DRAIN_TIMEOUT);
  localparam logic [DCNT_W-1:0] DCNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  FCNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_INVAL,
    S_WAIT_INV,
    S_ACK
  } state_e;

  // With the cache disabled the drain phase hands straight over to the ack.
  localparam state_e POST_DRAIN = ICACHE_EN ? S_INVAL : S_ACK;

  state_e            state;
  state_e            next_state;
  logic              set_timeout;
  logic [DCNT_W-1:0] drain_cnt;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    set_timeout = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fencei_flush_req_i) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (dbuf_empty_i) begin
          next_state = POST_DRAIN;
        end else if (TIMEOUT_EN && (drain_cnt == TIMEOUT_V)) begin
          next_state  = POST_DRAIN;
          set_timeout = 1'b1;
        end
      end
      S_INVAL: begin
        if (icache_inv_gnt_i) next_state = icache_inv_done_i ? S_ACK : S_WAIT_INV;
      end
      S_WAIT_INV: begin
        if (icache_inv_done_i) next_state = S_ACK;
      end
      S_ACK: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      drain_cnt          <= '0;
      fencei_flush_ack_o <= 1'b0;
      dbuf_drain_o       <= 1'b0;
      icache_inv_req_o   <= 1'b0;
      flush_busy_o       <= 1'b0;
      flush_count_o      <= '0;
      drain_timeout_o    <= 1'b0;
    end else begin
      state              <= next_state;
      fencei_flush_ack_o <= (next_state == S_ACK);
      dbuf_drain_o       <= (next_state == S_DRAIN);
      icache_inv_req_o   <= (next_state == S_INVAL);
      flush_busy_o       <= (next_state != S_IDLE);

      // Held at zero outside DRAIN so each drain starts from zero; saturates instead of wrapping.
      if (state != S_DRAIN) begin
        drain_cnt <= '0;
      end else if (drain_cnt != DCNT_MAX) begin
        drain_cnt <= drain_cnt + DCNT_W'(1);
      end

      if ((next_state == S_ACK) && (flush_count_o != FCNT_MAX)) begin
        flush_count_o <= flush_count_o + CNT_W'(1);
      end

      if (set_timeout) drain_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40x_fencei_flush_unit.sv
// Self-checking bench: three flush-unit configurations, a scoreboard of expected
// ack cycle and flush count per request, plus directed checks on the side outputs.
module tb_cv32e40x_fencei_flush_unit;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, empty, gnt, done;
  logic [2:0]  ack, drain, ireq, busy, tmo;
  logic [15:0] cnt0, cnt2;
  logic [1:0]  cnt1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   drain_n[3] = '{0, 0, 0};
  int   ireq_n[3]  = '{0, 0, 0};
  int   ack_n[3]   = '{0, 0, 0};
  exp_t q0[$], q1[$], q2[$];

  // u0: defaults, u1: small counter and short timeout, u2: no instruction cache.
  cv32e40x_fencei_flush_unit #(.CNT_W(16), .DRAIN_TIMEOUT(255), .ICACHE_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .fencei_flush_req_i(req[0]), .fencei_flush_ack_o(ack[0]),
    .dbuf_empty_i(empty[0]), .dbuf_drain_o(drain[0]), .icache_inv_req_o(ireq[0]),
    .icache_inv_gnt_i(gnt[0]), .icache_inv_done_i(done[0]), .flush_busy_o(busy[0]),
    .flush_count_o(cnt0), .drain_timeout_o(tmo[0]));

  cv32e40x_fencei_flush_unit #(.CNT_W(2), .DRAIN_TIMEOUT(8), .ICACHE_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .fencei_flush_req_i(req[1]), .fencei_flush_ack_o(ack[1]),
    .dbuf_empty_i(empty[1]), .dbuf_drain_o(drain[1]), .icache_inv_req_o(ireq[1]),
    .icache_inv_gnt_i(gnt[1]), .icache_inv_done_i(done[1]), .flush_busy_o(busy[1]),
    .flush_count_o(cnt1), .drain_timeout_o(tmo[1]));

  cv32e40x_fencei_flush_unit #(.CNT_W(16), .DRAIN_TIMEOUT(255), .ICACHE_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .fencei_flush_req_i(req[2]), .fencei_flush_ack_o(ack[2]),
    .dbuf_empty_i(empty[2]), .dbuf_drain_o(drain[2]), .icache_inv_req_o(ireq[2]),
    .icache_inv_gnt_i(gnt[2]), .icache_inv_done_i(done[2]), .flush_busy_o(busy[2]),
    .flush_count_o(cnt2), .drain_timeout_o(tmo[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int idx, input int cnt_v);
    exp_t e;
    int   ok;
    ok = 0;
    case (idx)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1; end
    endcase
    check($sformatf("u%0d_ack_expected", idx), ok, 1);
    if (ok == 1) begin
      check($sformatf("u%0d_ack_cycle", idx), cyc, e.cyc);
      check($sformatf("u%0d_ack_count", idx), cnt_v, e.cnt);
    end
  endtask

  task automatic check_idle(input int idx);
    int c;
    case (idx)
      0:       c = int'(cnt0);
      1:       c = int'(cnt1);
      default: c = int'(cnt2);
    endcase
    check($sformatf("u%0d_idle_ack", idx), int'(ack[idx]), 0);
    check($sformatf("u%0d_idle_drain", idx), int'(drain[idx]), 0);
    check($sformatf("u%0d_idle_ireq", idx), int'(ireq[idx]), 0);
    check($sformatf("u%0d_idle_busy", idx), int'(busy[idx]), 0);
    check($sformatf("u%0d_idle_tmo", idx), int'(tmo[idx]), 0);
    check($sformatf("u%0d_idle_count", idx), c, 0);
  endtask

  // Monitor: activity counters and scoreboard pop on every observed ack.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      drain_n[i] += int'(drain[i]);
      ireq_n[i]  += int'(ireq[i]);
      ack_n[i]   += int'(ack[i]);
    end
    if (!rst) begin
      if (ack[0]) sb_pop(0, int'(cnt0));
      if (ack[1]) sb_pop(1, int'(cnt1));
      if (ack[2]) sb_pop(2, int'(cnt2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, i0, a0, d1;
    rst = 1'b1; req = '0; empty = '0; gnt = '0; done = '0;
    repeat (2) tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i);
    rst = 1'b0;
    tick();

    // Basic: everything immediate, ack three cycles after the sampling edge.
    empty[0] = 1'b1; gnt[0] = 1'b1; done[0] = 1'b1;
    push_exp(0, cyc + 3, 1);
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("basic_busy", int'(busy[0]), (i <= 3) ? 1 : 0);
      tick();
    end
    check("basic_count", int'(cnt0), 1);

    // Backpressure: empty late by 10 cycles, gnt late by 4, done 6 after gnt.
    empty[0] = 1'b0; gnt[0] = 1'b0; done[0] = 1'b0;
    d0 = drain_n[0]; i0 = ireq_n[0]; a0 = ack_n[0];
    push_exp(0, cyc + 23, 2);
    req[0] = 1'b1;
    tick();
    repeat (10) tick();
    empty[0] = 1'b1;
    tick();
    repeat (4) tick();
    gnt[0] = 1'b1;
    tick();
    gnt[0] = 1'b0;
    repeat (5) tick();
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0; req[0] = 1'b0;
    repeat (3) tick();
    check("bp_drain_cycles", drain_n[0] - d0, 11);
    check("bp_ireq_cycles", ireq_n[0] - i0, 5);
    check("bp_ack_pulses", ack_n[0] - a0, 1);
    check("bp_timeout_flag", int'(tmo[0]), 0);

    // No instruction cache: ack two cycles after the sampling edge, no invalidate.
    empty[2] = 1'b1; gnt[2] = 1'b1; done[2] = 1'b1;
    push_exp(2, cyc + 2, 1);
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    repeat (4) tick();
    check("noic_ireq_cycles", ireq_n[2], 0);
    check("noic_count", int'(cnt2), 1);

    // Saturation: five back-to-back flushes with req held high throughout.
    empty[1] = 1'b1; gnt[1] = 1'b1; done[1] = 1'b1;
    for (int j = 0; j < 5; j++) push_exp(1, cyc + 3 + 4 * j, (j < 3) ? j + 1 : 3);
    req[1] = 1'b1;
    repeat (19) tick();
    req[1] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("sat_count", int'(cnt1), 3);
    check("sat_busy_after", int'(busy[1]), 0);

    // Timeout: empty never rises, flag and advance when the counter reaches 8.
    empty[1] = 1'b0;
    d1 = drain_n[1];
    push_exp(1, cyc + 11, 3);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("to_flag_before", int'(tmo[1]), 0);
    check("to_drain_last", int'(drain[1]), 1);
    tick();
    @(negedge clk);
    check("to_flag_set", int'(tmo[1]), 1);
    check("to_inval_req", int'(ireq[1]), 1);
    check("to_drain_off", int'(drain[1]), 0);
    repeat (3) tick();
    check("to_drain_cycles", drain_n[1] - d1, 9);
    empty[1] = 1'b1;
    push_exp(1, cyc + 3, 3);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    repeat (4) tick();
    check("to_flag_sticky", int'(tmo[1]), 1);

    // Reset during WAIT_INV: abandon the flush with no ack.
    empty[0] = 1'b1; gnt[0] = 1'b1; done[0] = 1'b0;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_busy_wait_inv", int'(busy[0]), 1);
    check("rst_ireq_after_gnt", int'(ireq[0]), 0);
    a0 = ack_n[0];
    rst = 1'b1;
    tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i);
    rst = 1'b0;
    repeat (2) tick();
    check("rst_no_ack", ack_n[0] - a0, 0);
    done[0] = 1'b1;
    push_exp(0, cyc + 3, 1);
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    repeat (4) tick();
    check("rst_later_count", int'(cnt0), 1);

    // Empty and timeout on the same cycle: empty wins, flag stays clear.
    empty[1] = 1'b0; gnt[1] = 1'b1; done[1] = 1'b1;
    push_exp(1, cyc + 11, 1);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    repeat (8) tick();
    empty[1] = 1'b1;
    repeat (4) tick();
    check("coincide_flag", int'(tmo[1]), 0);
    check("coincide_count", int'(cnt1), 1);

    check("u0_sb_pending", q0.size(), 0);
    check("u1_sb_pending", q1.size(), 0);
    check("u2_sb_pending", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
